// File: rtl/axi_bram_pkg.sv
// Shared types and helpers for the AXI4 block-RAM responder.
package axi_bram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for FIXED / INCR / WRAP bursts; purely combinational.
module axi_burst_addr
  import axi_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_size,
  input  logic [7:0]            i_len,
  input  burst_e                i_burst,
  output logic [ADDR_WIDTH-1:0] o_next
);

  logic [ADDR_WIDTH-1:0] step, incr, wmask;

  always_comb begin
    step  = ADDR_WIDTH'(1) << i_size;
    incr  = i_addr + step;
    // wrap window is (len+1)<<size bytes, aligned to its own size
    wmask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
    case (i_burst)
      BURST_INCR: o_next = incr;
      BURST_WRAP: o_next = (i_addr & ~wmask) | (incr & wmask);
      default:    o_next = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_bram_responder.sv
// AXI4 responder over an inferred byte-enable BRAM; one transaction at a time,
// read/write arbitration by last-served class, registered read plus skid slot.
module axi_bram_responder
  import axi_bram_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_BYTES  = 32'h10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);

  localparam int AW_IDX = $clog2(MEM_BYTES);
  localparam int WORDS  = MEM_BYTES / 8;

  state_e                  state_q, state_d;
  logic                    alive_q, alive_d;
  logic                    last_rd_q, last_rd_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, next_addr;
  logic [7:0]              len_q, len_d;
  logic [1:0]              size_q, size_d;
  burst_e                  burst_q, burst_d;
  logic                    err_q, err_d;
  logic [8:0]              cnt_q, cnt_d;
  logic                    ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic                    skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [DATA_WIDTH-1:0]   ram_q;
  logic [DATA_WIDTH-1:0]   mem [WORDS];
  logic [AW_IDX-4:0]       idx;

  logic aw_hs, ar_hs, w_hs, r_hs, idle_rdy, both_v, beat_last, r_issue, cur_last;
  logic [2:0] c_size;
  logic [1:0] c_burst;
  logic [7:0] c_len;
  logic       c_wrap_bad;

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .i_addr (addr_q),
    .i_size (size_q),
    .i_len  (len_q),
    .i_burst(burst_q),
    .o_next (next_addr)
  );

  // losing channel's ready drops when both request in the same cycle
  assign idle_rdy  = (state_q == ST_IDLE) && alive_q;
  assign both_v    = i_awvalid && i_arvalid;
  assign o_awready = idle_rdy && !(both_v && !last_rd_q);
  assign o_arready = idle_rdy && !(both_v && last_rd_q);
  assign aw_hs     = o_awready && i_awvalid;
  assign ar_hs     = o_arready && i_arvalid;

  assign o_wready  = (state_q == ST_WDATA);
  assign w_hs      = o_wready && i_wvalid;
  assign beat_last = (cnt_q[7:0] == len_q);
  assign o_bvalid  = (state_q == ST_WRESP);
  assign o_bid     = id_q;
  assign o_bresp   = err_q ? RESP_SLVERR : RESP_OKAY;

  assign r_issue   = (state_q == ST_RDATA) && (cnt_q <= {1'b0, len_q}) && !skid_vld_q;
  assign o_rvalid  = ram_vld_q || skid_vld_q;
  assign cur_last  = skid_vld_q ? skid_last_q : ram_last_q;
  assign r_hs      = o_rvalid && i_rready;
  assign o_rlast   = o_rvalid && cur_last;
  assign o_rid     = id_q;
  assign o_rresp   = err_q ? RESP_SLVERR : RESP_OKAY;
  assign o_rdata   = (o_rvalid && burst_q != BURST_RSVD) ? (skid_vld_q ? skid_data_q : ram_q) : '0;

  assign c_size     = aw_hs ? i_awsize  : i_arsize;
  assign c_burst    = aw_hs ? i_awburst : i_arburst;
  assign c_len      = aw_hs ? i_awlen   : i_arlen;
  assign c_wrap_bad = (c_burst == BURST_WRAP) && !wrap_len_ok(c_len);

  always_comb begin
    state_d     = state_q;
    alive_d     = 1'b1;
    last_rd_d   = last_rd_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_IDLE: if (aw_hs || ar_hs) begin
        state_d   = aw_hs ? ST_WDATA : ST_RDATA;
        last_rd_d = !aw_hs;
        id_d      = aw_hs ? i_awid : i_arid;
        addr_d    = aw_hs ? i_awaddr : i_araddr;
        len_d     = c_len;
        size_d    = c_size[2] ? 2'd3 : c_size[1:0];
        burst_d   = c_wrap_bad ? BURST_INCR : burst_e'(c_burst);
        err_d     = c_size[2] || (c_burst == BURST_RSVD) || c_wrap_bad;
        cnt_d     = '0;
      end
      ST_WDATA: if (w_hs) begin
        addr_d = next_addr;
        cnt_d  = cnt_q + 9'd1;
        if (i_wlast != beat_last) err_d = 1'b1;
        if (beat_last) state_d = ST_WRESP;
      end
      ST_WRESP: if (i_bready) state_d = ST_IDLE;
      default: if (r_hs && cur_last) state_d = ST_IDLE;
    endcase
    if (r_issue) begin
      addr_d     = next_addr;
      cnt_d      = cnt_q + 9'd1;
      ram_last_d = beat_last;
    end
    // skid holds the older beat whenever a stalled RAM output would be overwritten
    if (skid_vld_q) begin
      if (i_rready) skid_vld_d = 1'b0;
    end else if (ram_vld_q && !i_rready) begin
      if (r_issue) begin
        skid_vld_d  = 1'b1;
        skid_data_d = ram_q;
        skid_last_d = ram_last_q;
      end
    end else begin
      ram_vld_d = r_issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alive_q     <= 1'b0;
      last_rd_q   <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BURST_FIXED;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      last_rd_q   <= last_rd_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign idx = addr_q[AW_IDX-1:3];

  always_ff @(posedge clk) begin
    if (w_hs && burst_q != BURST_RSVD)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (i_wstrb[b]) mem[idx][8*b +: 8] <= i_wdata[8*b +: 8];
    if (r_issue) ram_q <= mem[idx];
  end

endmodule

// File: tb/tb_axi_bram_responder.sv
// Randomized bench for axi_bram_responder against a byte-level memory model.
module tb_axi_bram_responder;
  localparam int MEM_BYTES = 32'h10000;
  localparam int WORDS     = MEM_BYTES / 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  i_awid = '0, i_arid = '0, o_bid, o_rid;
  logic [31:0] i_awaddr = '0, i_araddr = '0;
  logic [7:0]  i_awlen = '0, i_arlen = '0, i_wstrb = '0;
  logic [2:0]  i_awsize = '0, i_arsize = '0;
  logic [1:0]  i_awburst = '0, i_arburst = '0, o_bresp, o_rresp;
  logic        i_awvalid = 0, i_arvalid = 0, i_wvalid = 0, i_wlast = 0, i_bready = 0, i_rready = 0;
  logic        o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast;
  logic [63:0] i_wdata = '0, o_rdata;

  int n_tests = 0, n_fail = 0;
  logic [63:0] mdata [WORDS];
  logic [7:0]  mknown [WORDS];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  axi_bram_responder #(.ID_WIDTH(6), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
    .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid),
    .i_rready(i_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // address of beat b from the burst rules, stated in closed form
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int b);
    logic [31:0] nb, wb, base;
    nb = 32'd1 << ((size > 3'd3) ? 3'd3 : size);
    if (burst == 2'b00 || burst == 2'b11) return a;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wb   = ({24'd0, len} + 32'd1) * nb;
      base = a - (a % wb);
      return base + ((a - base + 32'(b) * nb) % wb);
    end
    return a + 32'(b) * nb;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[$clog2(MEM_BYTES)-1:3]);
  endfunction

  function automatic logic exp_err(input logic [1:0] burst, input logic [2:0] size, input logic [7:0] len);
    return burst == 2'b11 || size > 3'd3 ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [63:0] bmask(input logic [7:0] k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{k[i]}};
    return r;
  endfunction

  task automatic fill_w(input bit rnd_strb);
    for (int i = 0; i < 256; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = rnd_strb ? 8'($urandom) : 8'hFF;
    end
  endtask

  task automatic set_aw(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    i_awid = id; i_awaddr = a; i_awlen = len; i_awsize = size; i_awburst = burst; i_awvalid = 1;
  endtask

  task automatic set_ar(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    i_arid = id; i_araddr = a; i_arlen = len; i_arsize = size; i_arburst = burst; i_arvalid = 1;
  endtask

  // called at negedge+1; returns at negedge+1 of the cycle after the B handshake
  task automatic axi_write(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit bad_wlast);
    int n, w;
    logic [31:0] ba;
    set_aw(id, a, len, size, burst);
    n = 0; #1;
    while (!o_awready && n < 100) begin @(negedge clk); #1; n++; end
    chk("aw_hs", 64'(o_awready), 64'd1);
    @(posedge clk); @(negedge clk);
    i_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      i_wvalid = 1; i_wdata = wd[b]; i_wstrb = ws[b];
      i_wlast = (b == int'(len)) ^ (bad_wlast && b == 0);
      n = 0; #1;
      while (!o_wready && n < 100) begin @(negedge clk); #1; n++; end
      if (b == 0 || b == int'(len)) chk("wready", 64'(o_wready), 64'd1);
      @(posedge clk); @(negedge clk);
    end
    i_wvalid = 0; i_wlast = 0;
    n = 0; #1;
    while (!o_bvalid && n < 100) begin @(negedge clk); #1; n++; end
    chk("bvalid", 64'(o_bvalid), 64'd1);
    chk("bid", 64'(o_bid), 64'(id));
    chk("bresp", 64'(o_bresp), (exp_err(burst, size, len) || bad_wlast) ? 64'd2 : 64'd0);
    i_bready = 1;
    @(posedge clk); @(negedge clk);
    i_bready = 0; #1;
    chk("aw_idle_after_b", 64'(o_awready || i_arvalid), 64'd1);
    if (burst != 2'b11)
      for (int b = 0; b <= int'(len); b++) begin
        ba = beat_addr(a, len, size, burst, b);
        w  = widx(ba);
        for (int k = 0; k < 8; k++)
          if (ws[b][k]) begin
            mdata[w][8*k +: 8] = wd[b][8*k +: 8];
            mknown[w][k] = 1'b1;
          end
      end
  endtask

  task automatic axi_read(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit rnd);
    int n, lat, w;
    logic [63:0] held, m, e;
    bit stalled;
    set_ar(id, a, len, size, burst);
    n = 0; #1;
    while (!o_arready && n < 100) begin @(negedge clk); #1; n++; end
    chk("ar_hs", 64'(o_arready), 64'd1);
    @(posedge clk); @(negedge clk);
    i_arvalid = 0;
    lat = 1; #1;
    while (!o_rvalid && lat < 100) begin @(negedge clk); #1; lat++; end
    chk("r_latency", 64'(lat), 64'd2);
    for (int b = 0; b <= int'(len); b++) begin
      i_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n = 0;
      while (!(o_rvalid && i_rready) && n < 200) begin
        stalled = o_rvalid; held = o_rdata;
        @(negedge clk);
        i_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1; n++;
        if (stalled) chk("rdata_hold", o_rdata, held);
      end
      chk("rvalid", 64'(o_rvalid), 64'd1);
      w = widx(beat_addr(a, len, size, burst, b));
      if (burst == 2'b11) begin m = '1; e = '0; end
      else begin m = bmask(mknown[w]); e = mdata[w]; end
      chk("rdata", o_rdata & m, e & m);
      chk("rlast", 64'(o_rlast), 64'(b == int'(len)));
      chk("rid", 64'(o_rid), 64'(id));
      chk("rresp", 64'(o_rresp), exp_err(burst, size, len) ? 64'd2 : 64'd0);
      @(posedge clk); @(negedge clk); #1;
    end
    i_rready = 0;
    chk("ar_idle_after_r", 64'(o_arready), 64'd1);
  endtask

  initial begin
    int got, n;
    for (int i = 0; i < WORDS; i++) begin mdata[i] = '0; mknown[i] = '0; end

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(o_awready), 64'd0);
    chk("rst_arready", 64'(o_arready), 64'd0);
    chk("rst_wready", 64'(o_wready), 64'd0);
    chk("rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("rst_rvalid", 64'(o_rvalid), 64'd0);
    chk("rst_rlast", 64'(o_rlast), 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);
    chk("rst_bresp", 64'({o_bid, o_bresp, o_rid, o_rresp}), 64'd0);

    // simultaneous AW/AR right after reset: write wins, then read wins
    fill_w(0);
    rst = 0;
    set_ar(6'h11, 32'h200, 8'd0, 3'd3, 2'b01);
    set_aw(6'h22, 32'h200, 8'd0, 3'd3, 2'b01);
    @(negedge clk); #1;
    chk("arb_first_aw", 64'(o_awready), 64'd1);
    chk("arb_first_ar", 64'(o_arready), 64'd0);
    axi_write(6'h22, 32'h200, 8'd0, 3'd3, 2'b01, 0);
    set_aw(6'h23, 32'h300, 8'd1, 3'd3, 2'b01);
    #1;
    chk("arb_second_ar", 64'(o_arready), 64'd1);
    chk("arb_second_aw", 64'(o_awready), 64'd0);
    axi_read(6'h11, 32'h200, 8'd0, 3'd3, 2'b01, 0);
    fill_w(0);
    axi_write(6'h23, 32'h300, 8'd1, 3'd3, 2'b01, 0);

    // single write then read
    fill_w(0);
    wd[0] = 64'h1122334455667788;
    axi_write(6'h01, 32'h100, 8'd0, 3'd3, 2'b01, 0);
    axi_read(6'h02, 32'h100, 8'd0, 3'd3, 2'b01, 0);

    // INCR with a partial strobe on beat 2, then read with random backpressure
    fill_w(0);
    axi_write(6'h03, 32'h0, 8'd3, 3'd3, 2'b01, 0);
    fill_w(0);
    ws[2] = 8'h0F;
    axi_write(6'h04, 32'h0, 8'd3, 3'd3, 2'b01, 0);
    axi_read(6'h05, 32'h0, 8'd3, 3'd3, 2'b01, 1);

    // WRAP legal and illegal lengths
    axi_read(6'h06, 32'h18, 8'd3, 3'd3, 2'b10, 0);
    axi_read(6'h07, 32'h18, 8'd2, 3'd3, 2'b10, 1);

    // error cases
    fill_w(0);
    axi_write(6'h08, 32'h400, 8'd1, 3'd3, 2'b01, 1);
    axi_read(6'h09, 32'h400, 8'd1, 3'd3, 2'b01, 0);
    fill_w(0);
    axi_write(6'h0A, 32'h100, 8'd0, 3'd3, 2'b11, 0);
    axi_read(6'h0B, 32'h100, 8'd0, 3'd3, 2'b01, 0);
    axi_read(6'h0C, 32'h100, 8'd0, 3'd3, 2'b11, 0);
    axi_read(6'h0D, 32'h0, 8'd1, 3'd5, 2'b01, 0);

    // narrow write, top-of-memory wrap with len=255, high-address alias
    fill_w(1);
    axi_write(6'h0E, 32'h41, 8'd3, 3'd0, 2'b01, 0);
    axi_read(6'h0F, 32'h40, 8'd0, 3'd3, 2'b01, 0);
    fill_w(0);
    axi_write(6'h10, 32'(MEM_BYTES - 64), 8'd255, 3'd3, 2'b01, 0);
    axi_read(6'h12, 32'(MEM_BYTES - 64), 8'd255, 3'd3, 2'b01, 1);
    axi_read(6'h13, 32'h1234_0100, 8'd0, 3'd3, 2'b01, 0);

    // random traffic
    for (int t = 0; t < 24; t++) begin
      logic [31:0] ra;
      logic [7:0]  rl;
      logic [2:0]  rs;
      logic [1:0]  rb;
      ra = $urandom; rl = 8'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 4)); rb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        fill_w(1);
        axi_write(6'($urandom), ra, rl, rs, rb, $urandom_range(0, 7) == 0);
      end else begin
        axi_read(6'($urandom), ra, rl, rs, rb, 1);
      end
    end

    // reset during beat 2 of a len=7 read
    set_ar(6'h2A, 32'h0, 8'd7, 3'd3, 2'b01);
    n = 0; #1;
    while (!o_arready && n < 100) begin @(negedge clk); #1; n++; end
    chk("rst_mid_ar_hs", 64'(o_arready), 64'd1);
    @(posedge clk); @(negedge clk);
    i_arvalid = 0; i_rready = 1;
    got = 0; n = 0;
    while (got < 3 && n < 50) begin
      @(negedge clk); #1; n++;
      if (o_rvalid) got++;
    end
    chk("rst_mid_beats", 64'(got), 64'd3);
    rst = 1; #1;
    chk("rst_mid_rvalid", 64'(o_rvalid), 64'd0);
    chk("rst_mid_rlast", 64'(o_rlast), 64'd0);
    @(negedge clk);
    rst = 0; i_rready = 0;
    @(negedge clk); #1;
    chk("rst_mid_arready", 64'(o_arready), 64'd1);
    axi_read(6'h2B, 32'h0, 8'd7, 3'd3, 2'b01, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
